// File: rtl/mp_mult_pkg.sv
// Shared types and constants for the multi-precision multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: op-mode enum, FP16/FP32 bias and special encodings, lane widths.
package mp_mult_pkg;

   typedef enum logic [1:0] {
      MODE_INT16  = 2'b00,
      MODE_INT8X2 = 2'b01,
      MODE_FP16   = 2'b10,
      MODE_UINT16 = 2'b11
   } mode_e;

   localparam int          LANE_W    = 16;
   localparam int          PROD_W    = 32;
   localparam int          ST_W      = 3;

   localparam int          FP16_BIAS = 15;
   localparam int          FP32_BIAS = 127;
   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP32_INF  = 32'h7F80_0000;

endpackage

// File: rtl/mp_mult_lane.sv
// One 16-bit lane of the multiplier, all four modes.
// Latency: 0 cycles (combinational, registered by the enclosing pipeline).
// Backpressure: none, pure function of operands and mode.
// Ports: mode, opa, opb (16b operands), prod (32b result),
//        status {nan, inf, zero} only when MP_MULT_STATUS_EN is defined.
module mp_mult_lane
   import mp_mult_pkg::*;
(
   input  mode_e       mode,
   input  logic [15:0] opa,
   input  logic [15:0] opb,
   output logic [31:0] prod
`ifdef MP_MULT_STATUS_EN
   ,
   output logic [2:0]  status
`endif
);

   // Integer 16x16: sign-extend only in signed mode, low 32 bits are exact either way.
   logic        ext_a, ext_b;
   logic signed [31:0] ia, ib, iprod;

   assign ext_a = (mode == MODE_INT16) & opa[15];
   assign ext_b = (mode == MODE_INT16) & opb[15];
   assign ia    = {{16{ext_a}}, opa};
   assign ib    = {{16{ext_b}}, opb};
   assign iprod = ia * ib;

   // INT8x2: two independent signed 8x8 products, each fits 16 bits.
   logic signed [15:0] ah, bh, al, bl, hi_p, lo_p;

   assign ah   = {{8{opa[15]}}, opa[15:8]};
   assign bh   = {{8{opb[15]}}, opb[15:8]};
   assign al   = {{8{opa[7]}},  opa[7:0]};
   assign bl   = {{8{opb[7]}},  opb[7:0]};
   assign hi_p = ah * bh;
   assign lo_p = al * bl;

   // FP16 x FP16 -> FP32. An 11x11 significand product fits in 23 FP32 fraction
   // bits, so the result is exact and needs no rounding. Exponent range of two
   // normal inputs (99..158 biased) never over- or underflows FP32.
   logic        fp_sgn;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic        fp_nan, fp_inf, fp_zero;
   logic [21:0] sig_a, sig_b, sig_p;
   logic [7:0]  fp_exp;
   logic [22:0] fp_frac;
   logic [31:0] fp_res;

   assign fp_sgn = opa[15] ^ opb[15];
   // Exponent 0 covers both true zero and subnormals, which flush to signed zero.
   assign a_zero = (opa[14:10] == 5'd0);
   assign b_zero = (opb[14:10] == 5'd0);
   assign a_inf  = (opa[14:10] == 5'h1F) && (opa[9:0] == 10'd0);
   assign b_inf  = (opb[14:10] == 5'h1F) && (opb[9:0] == 10'd0);
   assign a_nan  = (opa[14:10] == 5'h1F) && (opa[9:0] != 10'd0);
   assign b_nan  = (opb[14:10] == 5'h1F) && (opb[9:0] != 10'd0);

   assign fp_nan  = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
   assign fp_inf  = ~fp_nan & (a_inf | b_inf);
   assign fp_zero = ~fp_nan & ~fp_inf & (a_zero | b_zero);

   assign sig_a = {11'd0, 1'b1, opa[9:0]};
   assign sig_b = {11'd0, 1'b1, opb[9:0]};
   assign sig_p = sig_a * sig_b;

   // Significand product is in [1,4); bit 21 set means renormalise by one.
   assign fp_exp  = 8'(opa[14:10]) + 8'(opb[14:10])
                  + 8'(FP32_BIAS - 2 * FP16_BIAS) + {7'd0, sig_p[21]};
   assign fp_frac = sig_p[21] ? {sig_p[20:0], 2'b00} : {sig_p[19:0], 3'b000};

   always_comb begin
      fp_res = {fp_sgn, fp_exp, fp_frac};
      if (fp_nan)
         fp_res = FP32_QNAN;
      else if (fp_inf)
         fp_res = {fp_sgn, FP32_INF[30:0]};
      else if (fp_zero)
         fp_res = {fp_sgn, 31'd0};
   end

   always_comb begin
      prod = iprod;
      case (mode)
         MODE_INT16,
         MODE_UINT16: prod = iprod;
         MODE_INT8X2: prod = {hi_p, lo_p};
         MODE_FP16:   prod = fp_res;
         default:     prod = iprod;
      endcase
   end

`ifdef MP_MULT_STATUS_EN
   always_comb begin
      status = {2'b00, (prod == 32'd0)};
      if (mode == MODE_FP16)
         status = {fp_nan, fp_inf, fp_zero};
   end
`endif

endmodule

// File: rtl/mp_mult_pipe.sv
// Multi-lane multi-precision multiplier (INT16, UINT16, INT8x2, FP16->FP32).
// Latency: beat presented in the cycle after edge N shows out_valid_o after edge N+PIPE_STAGES.
// Backpressure: whole pipe stalls (no bubble collapse) when out_valid_o & ~out_ready_i or en_i low.
// Ports: clk_i, rst_n_i (sync, active-low), en_i, mode_i/opa_i/opb_i with in_valid_i/in_ready_o,
//        prod_o/mode_o with out_valid_o/out_ready_i, busy_o;
//        status_o (per lane {nan,inf,zero}) only when MP_MULT_STATUS_EN is defined.
module mp_mult_pipe
   import mp_mult_pkg::*;
#(
   parameter int NUM_LANES   = 4,
   parameter int PIPE_STAGES = 3
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          en_i,
   input  logic [1:0]                    mode_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [NUM_LANES*LANE_W-1:0]   opa_i,
   input  logic [NUM_LANES*LANE_W-1:0]   opb_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [NUM_LANES*PROD_W-1:0]   prod_o,
   output logic [1:0]                    mode_o,
   output logic                          busy_o
`ifdef MP_MULT_STATUS_EN
   ,
   output logic [NUM_LANES*ST_W-1:0]     status_o
`endif
);

   localparam int PW = NUM_LANES * PROD_W;

   logic          advance;
   logic [PW-1:0] lane_prod;

   logic [PIPE_STAGES-1:0] stg_vld;
   logic [PW-1:0]          stg_prod [PIPE_STAGES];
   logic [1:0]             stg_mode [PIPE_STAGES];

`ifdef MP_MULT_STATUS_EN
   logic [NUM_LANES*ST_W-1:0] lane_st;
   logic [NUM_LANES*ST_W-1:0] stg_st [PIPE_STAGES];
`endif

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      mp_mult_lane u_lane (
         .mode   (mode_e'(mode_i)),
         .opa    (opa_i[LANE_W*k +: LANE_W]),
         .opb    (opb_i[LANE_W*k +: LANE_W]),
         .prod   (lane_prod[PROD_W*k +: PROD_W])
`ifdef MP_MULT_STATUS_EN
         ,
         .status (lane_st[ST_W*k +: ST_W])
`endif
      );
   end

   // A single advance strobe moves every stage together, so a held output
   // also holds everything behind it and the input.
   assign advance    = en_i & (~out_valid_o | out_ready_i);
   assign in_ready_o = advance;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         stg_vld <= '0;
         for (int s = 0; s < PIPE_STAGES; s++) begin
            stg_prod[s] <= '0;
            stg_mode[s] <= '0;
`ifdef MP_MULT_STATUS_EN
            stg_st[s]   <= '0;
`endif
         end
      end else if (advance) begin
         stg_vld[0]  <= in_valid_i;
         stg_prod[0] <= lane_prod;
         stg_mode[0] <= mode_i;
`ifdef MP_MULT_STATUS_EN
         stg_st[0]   <= lane_st;
`endif
         for (int s = 1; s < PIPE_STAGES; s++) begin
            stg_vld[s]  <= stg_vld[s-1];
            stg_prod[s] <= stg_prod[s-1];
            stg_mode[s] <= stg_mode[s-1];
`ifdef MP_MULT_STATUS_EN
            stg_st[s]   <= stg_st[s-1];
`endif
         end
      end
   end

   assign out_valid_o = stg_vld[PIPE_STAGES-1];
   assign prod_o      = stg_prod[PIPE_STAGES-1];
   assign mode_o      = stg_mode[PIPE_STAGES-1];
   assign busy_o      = |stg_vld;
`ifdef MP_MULT_STATUS_EN
   assign status_o    = stg_st[PIPE_STAGES-1];
`endif

endmodule

// File: tb/tb_mp_mult_pipe.sv
// Directed testbench for mp_mult_pipe with an in-order scoreboard.
// Latency: checks 3-cycle accept-to-output latency and stall/enable/reset behaviour.
// Backpressure: drives out_ready_i and en_i low mid-stream.
module tb_mp_mult_pipe;
   import mp_mult_pkg::*;

   localparam int NL = 4;

   logic          clk = 1'b0;
   logic          rst_n, en, in_valid, in_ready, out_valid, out_ready, busy;
   logic [1:0]    mode_in, mode_out;
   logic [NL*16-1:0] opa, opb;
   logic [NL*32-1:0] prod;
`ifdef MP_MULT_STATUS_EN
   logic [NL*3-1:0]  status;
`endif

   always #5 clk = ~clk;

   mp_mult_pipe #(.NUM_LANES(NL), .PIPE_STAGES(3)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .en_i        (en),
      .mode_i      (mode_in),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .opa_i       (opa),
      .opb_i       (opb),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .prod_o      (prod),
      .mode_o      (mode_out),
      .busy_o      (busy)
`ifdef MP_MULT_STATUS_EN
      ,
      .status_o    (status)
`endif
   );

   typedef struct {
      logic [NL*32-1:0] prod;
      logic [1:0]       mode;
      logic             cs;
      logic [NL*3-1:0]  st;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   nrecv    = 0;

   function automatic logic [63:0] rep16(input logic [15:0] v);
      return {4{v}};
   endfunction

   function automatic logic [127:0] rep32(input logic [31:0] v);
      return {4{v}};
   endfunction

   // Reference for the integer modes, written with native int arithmetic.
   function automatic logic [31:0] imodel(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
      int          s;
      int unsigned u;
      shortint     h, l;
      s = int'($signed(a)) * int'($signed(b));
      u = int'({16'd0, a}) * int'({16'd0, b});
      h = shortint'($signed(a[15:8])) * shortint'($signed(b[15:8]));
      l = shortint'($signed(a[7:0]))  * shortint'($signed(b[7:0]));
      case (m)
         2'b00:   return s;
         2'b11:   return u;
         2'b01:   return {h, l};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic send(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b,
                       input logic [127:0] e, input logic cs, input logic [11:0] es);
      int   n;
      logic acc;
      exp_t ent;
      mode_in  = m;
      opa      = a;
      opb      = b;
      in_valid = 1'b1;
      acc      = 1'b0;
      n        = 0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) begin
            ent.prod = e; ent.mode = m; ent.cs = cs; ent.st = es;
            sb.push_back(ent);
         end
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      checks++;
      assert (acc === 1'b1)
         else begin failures++; $error("FAIL send_accept observed=%b expected=1", acc); end
   endtask

   task automatic send_int(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] e;
      for (int k = 0; k < NL; k++)
         e[32*k +: 32] = imodel(m, a[16*k +: 16], b[16*k +: 16]);
      send(m, a, b, e, 1'b0, 12'd0);
   endtask

   // Output monitor: pops the scoreboard on every transferred result beat.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && en && out_valid && out_ready) begin
         checks++;
         assert (sb.size() > 0)
            else begin failures++; $error("FAIL unexpected_beat observed=%h expected=none", prod); end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            nrecv++;
            checks++;
            assert (prod === e.prod)
               else begin failures++; $error("FAIL prod observed=%h expected=%h", prod, e.prod); end
            checks++;
            assert (mode_out === e.mode)
               else begin failures++; $error("FAIL mode_o observed=%b expected=%b", mode_out, e.mode); end
`ifdef MP_MULT_STATUS_EN
            if (e.cs) begin
               checks++;
               assert (status === e.st)
                  else begin failures++; $error("FAIL status observed=%h expected=%h", status, e.st); end
            end
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_drained(input string tag);
      repeat (8) @(posedge clk);
      #1;
      checks++;
      assert (sb.size() === 0)
         else begin failures++; $error("FAIL %s_drain observed=%0d expected=0", tag, sb.size()); end
      checks++;
      assert (busy === 1'b0)
         else begin failures++; $error("FAIL %s_busy observed=%b expected=0", tag, busy); end
   endtask

   logic [15:0]  fa [8] = '{16'h3C00, 16'h3E00, 16'hBC00, 16'h0000, 16'h0001, 16'h7C00, 16'h7C00, 16'h7E00};
   logic [15:0]  fb [8] = '{16'h4000, 16'h3E00, 16'h4000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h0000, 16'h3C00};
   logic [31:0]  fe [8] = '{32'h40000000, 32'h40100000, 32'hC0000000, 32'h00000000,
                            32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000};

   initial begin
      int           lat;
      logic [127:0] held;
      logic [63:0]  a, b;
      logic [1:0]   m;
      exp_t         ent;

      rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      mode_in = 2'b00; opa = '0; opb = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checks++; assert (out_valid === 1'b0) else begin failures++; $error("FAIL rst_out_valid observed=%b expected=0", out_valid); end
      checks++; assert (busy === 1'b0)      else begin failures++; $error("FAIL rst_busy observed=%b expected=0", busy); end
      checks++; assert (prod === '0)        else begin failures++; $error("FAIL rst_prod observed=%h expected=0", prod); end
      checks++; assert (mode_out === 2'b00) else begin failures++; $error("FAIL rst_mode observed=%b expected=0", mode_out); end
`ifdef MP_MULT_STATUS_EN
      checks++; assert (status === '0)      else begin failures++; $error("FAIL rst_status observed=%h expected=0", status); end
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency: beat driven after an edge must be valid after the third following edge.
      ent.prod = rep32(32'h0000_0006); ent.mode = MODE_INT16; ent.cs = 1'b0; ent.st = '0;
      mode_in = MODE_INT16; opa = rep16(16'h0003); opb = rep16(16'h0002); in_valid = 1'b1;
      sb.push_back(ent);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 10);
      checks++;
      assert (lat === 3) else begin failures++; $error("FAIL latency observed=%0d expected=3", lat); end
      check_drained("lat");

      // Integer directed vectors
      send(MODE_INT16,  rep16(16'hFFFD), rep16(16'h0002), rep32(32'hFFFF_FFFA), 1'b0, 12'd0);
      send(MODE_UINT16, rep16(16'hFFFF), rep16(16'hFFFF), rep32(32'hFFFE_0001), 1'b0, 12'd0);
      send(MODE_INT8X2, rep16(16'h03FD), rep16(16'h0202), rep32(32'h0006_FFFA), 1'b0, 12'd0);
      // FP16 directed vectors; only the 0*inf case checks status
      for (int i = 0; i < 8; i++)
         send(MODE_FP16, rep16(fa[i]), rep16(fb[i]), rep32(fe[i]), (i == 6), 12'h924);
      check_drained("dir");

      // Backpressure: 8 distinct beats, out_ready low for 3 cycles mid-stream
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               m = (i % 3 == 0) ? MODE_INT16 : (i % 3 == 1) ? MODE_UINT16 : MODE_INT8X2;
               for (int k = 0; k < NL; k++) begin
                  a[16*k +: 16] = 16'(i * 4099 + k * 13001 + 7);
                  b[16*k +: 16] = 16'(i * 2311 + k * 30011 + 32769);
               end
               send_int(m, a, b);
            end
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b0;
            held = prod;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               checks++; assert (in_ready === 1'b0)  else begin failures++; $error("FAIL stall_in_ready observed=%b expected=0", in_ready); end
               checks++; assert (out_valid === 1'b1) else begin failures++; $error("FAIL stall_out_valid observed=%b expected=1", out_valid); end
               checks++; assert (prod === held)      else begin failures++; $error("FAIL stall_prod observed=%h expected=%h", prod, held); end
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      check_drained("bp");
      checks++;
      assert (nrecv === 20) else begin failures++; $error("FAIL recv_count observed=%0d expected=20", nrecv); end

      // Enable low with a full pipe
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               for (int k = 0; k < NL; k++) begin
                  a[16*k +: 16] = 16'(i * 517 + k * 9001 + 3);
                  b[16*k +: 16] = 16'(i * 7919 + k * 123 + 40000);
               end
               send_int(MODE_INT16, a, b);
            end
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            en = 1'b0;
            held = prod;
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               checks++; assert (in_ready === 1'b0)  else begin failures++; $error("FAIL en_in_ready observed=%b expected=0", in_ready); end
               checks++; assert (out_valid === 1'b1) else begin failures++; $error("FAIL en_out_valid observed=%b expected=1", out_valid); end
               checks++; assert (busy === 1'b1)      else begin failures++; $error("FAIL en_busy observed=%b expected=1", busy); end
               checks++; assert (prod === held)      else begin failures++; $error("FAIL en_prod observed=%h expected=%h", prod, held); end
            end
            @(posedge clk);
            #1;
            en = 1'b1;
         end
      join
      check_drained("en");

      // Reset with two beats in flight; nothing may emerge afterwards
      send_int(MODE_UINT16, rep16(16'h1234), rep16(16'h0010));
      send_int(MODE_INT16,  rep16(16'h8000), rep16(16'h0002));
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++; assert (out_valid === 1'b0) else begin failures++; $error("FAIL midrst_out_valid observed=%b expected=0", out_valid); end
      checks++; assert (busy === 1'b0)      else begin failures++; $error("FAIL midrst_busy observed=%b expected=0", busy); end
      rst_n = 1'b1;
      sb.delete();
      check_drained("rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mp_mult_pipe.md
Name: mp_mult_pipe

Overview:
Pipelined, multi-lane, multi-precision multiplier; successor to the single-lane 16-bit int/fp16 multiplier. Supports NUM_LANES independent 16-bit lanes and four modes: INT16 signed, UINT16, INT8x2 SIMD and FP16->FP32 exact. Uses a valid/ready handshake with full backpressure. Sits between the pre-process operand fetch and the accumulate stage.

Parameters:
NUM_LANES, 4, number of parallel 16-bit lanes (>=1)
PIPE_STAGES, 3, input-accept to out_valid_o latency in cycles (>=2)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  synchronous reset, active-low
en_i  in  1  global enable; low freezes the whole pipeline
mode_i  in  2  op mode, sampled with input beat
in_valid_i  in  1  input beat valid
in_ready_o  out  1  block can accept a beat this cycle
opa_i  in  NUM_LANES*16  operand A, lane k at [16k+15:16k]
opb_i  in  NUM_LANES*16  operand B, same packing
out_valid_o  out  1  result beat valid
out_ready_i  in  1  downstream accepts result
prod_o  out  NUM_LANES*32  products, lane k at [32k+31:32k]
mode_o  out  2  mode carried with the result beat
busy_o  out  1  any pipeline stage holds a valid beat

Behaviour:
- Reset: rst_n_i sampled low at a clock edge clears all stage valid bits and zeroes prod_o, mode_o and status. out_valid_o=0, busy_o=0. Reset mid-flight discards all beats; no stale beat may appear after reset.
- Modes: 00 INT16 signed (32-bit two's-complement product). 01 INT8x2 (per lane: hi bytes signed 8x8 -> prod[31:16], lo bytes -> prod[15:0], each 16-bit signed). 10 FP16 -> FP32. 11 UINT16.
- FP16 product is exact in FP32; no rounding. Exponent is ea+eb-30+127 plus normalisation, sign = sa^sb.
- Subnormal FP16 inputs flush to zero (signed zero).
- inf*finite-nonzero = signed inf. NaN input or 0*inf = canonical NaN 32'h7FC00000.
- Pipeline: PIPE_STAGES register stages, each with a valid bit. Mode travels with data. Throughput 1 beat/cycle.
- advance = en_i & (~out_valid_o | out_ready_i). in_ready_o = advance.
- Input beat accepted when in_valid_i & in_ready_o. All stages shift only on advance. Bubbles do not collapse.
- Without a stall, a beat accepted at edge N gives out_valid_o=1 after edge N+PIPE_STAGES.
- out_valid_o & !out_ready_i: prod_o and mode_o held stable, no new beat accepted.
- Simultaneous accept at input and drain at output in the same cycle is legal and required for full throughput.
- en_i low: no accept, no advance, outputs held, valid bits preserved. out_valid_o stays asserted if set.
- busy_o = OR of all stage valid bits.
- Lanes are fully independent; lane results depend only on lane operands and mode.

Optional Feature:
MP_MULT_STATUS_EN: adds output status_o [NUM_LANES*3], per lane {nan, inf, zero}, aligned with prod_o and reset to 0. Flags are meaningful in FP16 mode. In integer modes only zero is meaningful (product == 0), nan and inf are 0. Without the macro, the port and its pipeline registers do not exist.

Decomposition:
- Package mp_mult_pkg holds:
  - mode typedef enum (MODE_INT16, MODE_INT8X2, MODE_FP16, MODE_UINT16)
  - FP16_BIAS=15, FP32_BIAS=127, FP32_QNAN=32'h7FC00000, FP32_INF=32'h7F800000
  - lane width constants 16/32
- Sub-module mp_mult_lane: combinational per-lane multiply for all modes (plus status). Instantiated NUM_LANES times in stage 1; the remaining stages delay and register.

Test Plan:
1. INT16, lane0: 0x0003*0x0002 -> 0x00000006. 0xFFFD*0x0002 -> 0xFFFFFFFA. Out exactly 3 cycles after accept.
2. UINT16: 0xFFFF*0xFFFF -> 0xFFFE0001. INT8x2: 0x03FD*0x0202 -> 0x0006FFFA.
3. FP16:
   - 0x3C00*0x4000 -> 0x40000000
   - 0x3E00*0x3E00 -> 0x40100000
   - 0xBC00*0x4000 -> 0xC0000000
   - 0x0000*0x3C00 -> 0x00000000
   - 0x0001*0x3C00 -> 0x00000000 (FTZ)
   - 0x7C00*0x3C00 -> 0x7F800000
   - 0x7C00*0x0000 -> 0x7FC00000
   - 0x7E00*0x3C00 -> 0x7FC00000
4. Backpressure: stream 8 beats with distinct values on 4 lanes and hold out_ready_i low for 3 cycles mid-stream -> in_ready_o low during the stall, prod_o stable, all 8 results in order with no loss or duplication.
5. Reset mid-flight: 2 beats in pipe, rst_n_i low one cycle -> out_valid_o=0 and busy_o=0 after that edge, no stale output afterwards.
6. en_i low for 4 cycles with a full pipe -> no accept, outputs frozen. Resumes with the correct sequence. With MP_MULT_STATUS_EN, 0x7C00*0x0000 sets nan=1 only.
